ofdm_fft_feeder: RTL and testbench

Subcarrier mapper and packet sequencer that feeds the FFT II core of the OFDM modulator. Consumes mapped QAM symbols from the upstream modulator stream, places them on the data bins of an NFFT-point frame, inserts zero (DC/guard) and pilot bins, and drives the FFT sink Avalon-ST port with correct sop/eop framing under ready backpressure. Sits directly between the QAM mapper and the fft_ii_0 sink.

---
 rtl/ofdm_fft_feeder_if.sv | 52 +++++
 rtl/ofdm_fft_feeder.sv | 175 +++++++++++++++++
 tb/tb_ofdm_fft_feeder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_fft_feeder_if.sv
// ---------------------------------------------------------------------------
// ofdm_fft_feeder_if
// Groups the two streaming ports of the FFT feeder: the upstream QAM symbol
// stream and the Avalon-ST sink of the fft_ii_0 core.
//
//   sym_valid / sym_ready / sym_data    upstream symbols, sym_data = {re, im}
//   fft_ii_0_sink_valid / _ready        FFT sink handshake (ready latency 0)
//   fft_ii_0_sink_error                 always zero
//   fft_ii_0_sink_startofpacket         bin 0 of a symbol
//   fft_ii_0_sink_endofpacket           bin NFFT-1 of a symbol
//   fft_ii_0_sink_data                  {inverse, re, im}
//
// Modports: master = the feeder, slave = the surrounding environment.
// ---------------------------------------------------------------------------
interface ofdm_fft_feeder_if #(
   parameter int DW = 16
) ();
   logic            sym_valid;
   logic            sym_ready;
   logic [2*DW-1:0] sym_data;

   logic            fft_ii_0_sink_valid;
   logic            fft_ii_0_sink_ready;
   logic [1:0]      fft_ii_0_sink_error;
   logic            fft_ii_0_sink_startofpacket;
   logic            fft_ii_0_sink_endofpacket;
   logic [2*DW:0]   fft_ii_0_sink_data;

   modport master (
      input  sym_valid,
      input  sym_data,
      output sym_ready,
      input  fft_ii_0_sink_ready,
      output fft_ii_0_sink_valid,
      output fft_ii_0_sink_error,
      output fft_ii_0_sink_startofpacket,
      output fft_ii_0_sink_endofpacket,
      output fft_ii_0_sink_data
   );

   modport slave (
      output sym_valid,
      output sym_data,
      input  sym_ready,
      output fft_ii_0_sink_ready,
      input  fft_ii_0_sink_valid,
      input  fft_ii_0_sink_error,
      input  fft_ii_0_sink_startofpacket,
      input  fft_ii_0_sink_endofpacket,
      input  fft_ii_0_sink_data
   );
endinterface

// File: rtl/ofdm_fft_feeder.sv
// ---------------------------------------------------------------------------
// ofdm_fft_feeder
// Subcarrier mapper / packet sequencer in front of the fft_ii_0 core. Walks
// bin index k over an NFFT-point frame, emitting zero on DC/guard bins, fixed
// pilots on pilot bins and the next upstream QAM symbol on data bins, framed
// with sop (k=0) and eop (k=NFFT-1). Whole symbols only: a drop of en takes
// effect at the next symbol boundary.
//
// Ports:
//   clk_clk       clock
//   reset_reset   asynchronous active-high reset
//   en            run request, sampled at symbol boundaries
//   cfg_inverse   inverse-FFT flag, latched at the start of each symbol
//   st            stream bundle (upstream symbols + FFT sink), master side
//   busy          high while in RUN
//   sym_count     completed symbols, wraps at 16 bits
// ---------------------------------------------------------------------------
module ofdm_fft_feeder #(
   parameter int                    NFFT        = 64,
   parameter int                    DW          = 16,
   parameter int                    GUARD_START = 27,
   parameter int                    GUARD_END   = 37,
   parameter int                    PILOT0      = 7,
   parameter int                    PILOT1      = 21,
   parameter int                    PILOT2      = 43,
   parameter int                    PILOT3      = 57,
   parameter logic signed [DW-1:0]  PILOT_AMP   = 16'sd11585
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               en,
   input  logic               cfg_inverse,
   ofdm_fft_feeder_if.master  st,
   output logic               busy,
   output logic [15:0]        sym_count
);

   localparam int KW = $clog2(NFFT);

   localparam logic [KW-1:0] K_LAST = KW'(NFFT - 1);
   localparam logic [KW-1:0] K_GS   = KW'(GUARD_START);
   localparam logic [KW-1:0] K_GE   = KW'(GUARD_END);
   localparam logic [KW-1:0] K_P0   = KW'(PILOT0);
   localparam logic [KW-1:0] K_P1   = KW'(PILOT1);
   localparam logic [KW-1:0] K_P2   = KW'(PILOT2);
   localparam logic [KW-1:0] K_P3   = KW'(PILOT3);

   localparam logic signed [DW-1:0] PILOT_NEG = -PILOT_AMP;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic           inv_q, inv_d;
   logic [15:0]    count_q, count_d;

   logic           out_valid_q;
   logic           out_sop_q;
   logic           out_eop_q;
   logic [2*DW:0]  out_data_q;

   logic                  is_null;
   logic                  is_pilot;
   logic                  is_data;
   logic signed [DW-1:0]  bin_re;
   logic signed [DW-1:0]  bin_im;

   logic run;
   logic slot_free;
   logic load;
   logic last_bin;

   // Bin classification; NULL takes precedence over a pilot index that
   // happens to fall on DC or inside the guard band.
   always_comb begin
      is_null  = (k_q == '0) || ((k_q >= K_GS) && (k_q <= K_GE));
      is_pilot = !is_null &&
                 ((k_q == K_P0) || (k_q == K_P1) || (k_q == K_P2) || (k_q == K_P3));
      is_data  = !is_null && !is_pilot;
      bin_re   = '0;
      bin_im   = '0;
      if (is_pilot) begin
         bin_re = (k_q == K_P3) ? PILOT_NEG : PILOT_AMP;
      end else if (is_data) begin
         bin_re = st.sym_data[2*DW-1:DW];
         bin_im = st.sym_data[DW-1:0];
      end
   end

   // The output register can take a new beat when empty or being drained
   // this cycle; data bins additionally need an upstream symbol.
   assign run       = (state_q == S_RUN);
   assign slot_free = !out_valid_q || st.fft_ii_0_sink_ready;
   assign load      = run && slot_free && (!is_data || st.sym_valid);
   assign last_bin  = (k_q == K_LAST);

   assign st.sym_ready = run && is_data && slot_free;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      inv_d   = inv_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_RUN;
               k_d     = '0;
               inv_d   = cfg_inverse;
            end
         end
         S_RUN: begin
            if (load) begin
               if (last_bin) begin
                  count_d = count_q + 16'd1;
                  k_d     = '0;
                  if (en) begin
                     inv_d = cfg_inverse;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         inv_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         inv_q   <= inv_d;
         count_q <= count_d;
      end
   end

   // Output register: holds data/sop/eop while stalled, clears valid once
   // the last beat drains with nothing new to load.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_data_q  <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_sop_q   <= (k_q == '0);
         out_eop_q   <= last_bin;
         out_data_q  <= {inv_q, bin_re, bin_im};
      end else if (st.fft_ii_0_sink_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign st.fft_ii_0_sink_valid         = out_valid_q;
   assign st.fft_ii_0_sink_startofpacket = out_sop_q;
   assign st.fft_ii_0_sink_endofpacket   = out_eop_q;
   assign st.fft_ii_0_sink_data          = out_data_q;
   assign st.fft_ii_0_sink_error         = 2'b00;

   assign busy      = run;
   assign sym_count = count_q;

endmodule

// File: tb/tb_ofdm_fft_feeder.sv
// ---------------------------------------------------------------------------
// tb_ofdm_fft_feeder
// Directed bench for ofdm_fft_feeder with default parameters. Upstream words
// are {n, ~n} for the n-th accepted symbol (n from 1); each sink beat is
// compared against a bin map held in the bench and a queue of accepted
// upstream words.
// ---------------------------------------------------------------------------
module tb_ofdm_fft_feeder;
   localparam int DW   = 16;
   localparam int NFFT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        cfg_inverse = 1'b0;
   logic        busy;
   logic [15:0] sym_count;

   ofdm_fft_feeder_if #(.DW(DW)) st ();

   ofdm_fft_feeder #(.NFFT(NFFT), .DW(DW)) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .en          (en),
      .cfg_inverse (cfg_inverse),
      .st          (st),
      .busy        (busy),
      .sym_count   (sym_count)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- upstream source ----------------
   int          up_seq = 0;
   int          budget = 0;
   logic        up_take;
   logic [31:0] up_d;
   logic [31:0] q[$];

   function automatic logic [31:0] up_word(input int n);
      logic [15:0] r;
      r = 16'(n + 1);
      return {r, ~r};
   endfunction

   always begin
      @(negedge clk);
      up_take = st.sym_valid && st.sym_ready && !rst;
      up_d    = st.sym_data;
      @(posedge clk);
      #1;
      if (up_take) begin
         q.push_back(up_d);
         up_seq++;
         budget--;
      end
      st.sym_valid = (budget > 0);
      st.sym_data  = up_word(up_seq);
   end

   // ---------------- sink monitor ----------------
   int          cyc = 0;
   int          nbeats = 0;
   int          exp_k = 0;
   int          sop_cyc = 0;
   int          eop_cyc = 0;
   int          n_stall = 0;
   logic        exp_inv = 1'b0;
   logic        prev_stall = 1'b0;
   logic [35:0] prev_snap = '0;
   logic        last_sop = 1'b0;
   logic [15:0] m_re, m_im;
   logic [31:0] m_d;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_stall++;
            check("hold", {st.fft_ii_0_sink_valid, st.fft_ii_0_sink_startofpacket,
                           st.fft_ii_0_sink_endofpacket, st.fft_ii_0_sink_data}, prev_snap);
         end
         if (st.fft_ii_0_sink_valid && st.fft_ii_0_sink_ready) begin
            m_re = '0;
            m_im = '0;
            if (exp_k == 7 || exp_k == 21 || exp_k == 43) begin
               m_re = 16'd11585;
            end else if (exp_k == 57) begin
               m_re = 16'hD2BF;
            end else if (exp_k != 0 && !(exp_k >= 27 && exp_k <= 37)) begin
               m_d  = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
               m_re = m_d[31:16];
               m_im = m_d[15:0];
            end
            check("beat", {st.fft_ii_0_sink_error, st.fft_ii_0_sink_startofpacket,
                           st.fft_ii_0_sink_endofpacket, st.fft_ii_0_sink_data},
                  {2'b00, (exp_k == 0), (exp_k == NFFT - 1), exp_inv, m_re, m_im});
            if (st.fft_ii_0_sink_startofpacket) sop_cyc = cyc;
            if (st.fft_ii_0_sink_endofpacket)   eop_cyc = cyc;
            last_sop = st.fft_ii_0_sink_startofpacket;
            nbeats++;
            exp_k = (exp_k + 1) % NFFT;
         end
         prev_stall = st.fft_ii_0_sink_valid && !st.fft_ii_0_sink_ready;
         prev_snap  = {st.fft_ii_0_sink_valid, st.fft_ii_0_sink_startofpacket,
                       st.fft_ii_0_sink_endofpacket, st.fft_ii_0_sink_data};
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_budget(input int v);
      @(negedge clk);
      budget = v;
   endtask

   task automatic wait_idle(input int max_cyc);
      int i;
      i = 0;
      while ((busy || st.fft_ii_0_sink_valid) && i < max_cyc) begin
         tick();
         i++;
      end
      check("idle_wait", {busy, st.fft_ii_0_sink_valid}, 2'b00);
   endtask

   task automatic wait_beats(input int target, input int max_cyc);
      int i;
      i = 0;
      while (nbeats < target && i < max_cyc) begin
         tick();
         i++;
      end
      check("beat_wait", (nbeats >= target), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int          base_b, base_u;
   logic [15:0] lfsr = 16'hACE1;

   initial begin
      st.fft_ii_0_sink_ready = 1'b1;
      set_budget(1_000_000);
      tick();
      // reset state
      check("rst_ctl", {st.fft_ii_0_sink_valid, st.fft_ii_0_sink_startofpacket,
                        st.fft_ii_0_sink_endofpacket, st.fft_ii_0_sink_error,
                        st.sym_ready, busy}, 7'd0);
      check("rst_data", st.fft_ii_0_sink_data, 0);
      check("rst_count", sym_count, 0);
      rst = 1'b0;
      tick();

      // continuous flow, one symbol, first-beat latency
      base_b = nbeats;
      base_u = up_seq;
      en = 1'b1;
      @(negedge clk);
      check("pre_busy", busy, 0);
      tick();
      en = 1'b0;
      @(negedge clk);
      check("run_busy", {busy, st.fft_ii_0_sink_valid}, 2'b10);
      @(negedge clk);
      check("first_sop", {st.fft_ii_0_sink_valid, st.fft_ii_0_sink_startofpacket}, 2'b11);
      tick();
      wait_idle(200);
      check("c_beats", nbeats - base_b, 64);
      check("c_up", up_seq - base_u, 48);
      check("c_count", sym_count, 1);
      check("c_contig", eop_cyc - sop_cyc, 63);

      // backpressure with inverse set
      cfg_inverse = 1'b1;
      exp_inv     = 1'b1;
      base_b = nbeats;
      base_u = up_seq;
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int c = 0; c < 300; c++) begin
         tick();
         st.fft_ii_0_sink_ready = lfsr[0];
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      st.fft_ii_0_sink_ready = 1'b1;
      wait_idle(200);
      check("bp_beats", nbeats - base_b, 64);
      check("bp_up", up_seq - base_u, 48);
      check("bp_count", sym_count, 2);
      check("bp_stalled", (n_stall > 0), 1);
      cfg_inverse = 1'b0;
      exp_inv     = 1'b0;

      // upstream starvation at bin 5
      set_budget(4);
      base_b = nbeats;
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (20) tick();
      check("st_beats", nbeats - base_b, 5);
      check("st_gap", {st.fft_ii_0_sink_valid, st.sym_ready, st.sym_valid}, 3'b010);
      set_budget(1_000_000);
      tick();
      wait_idle(200);
      check("st_total", nbeats - base_b, 64);
      check("st_count", sym_count, 3);

      // en drop at bin 20 with cfg_inverse toggled mid-symbol
      cfg_inverse = 1'b1;
      exp_inv     = 1'b1;
      base_b = nbeats;
      en = 1'b1;
      wait_beats(base_b + 20, 200);
      en = 1'b0;
      cfg_inverse = 1'b0;
      wait_idle(200);
      check("ed_beats", nbeats - base_b, 64);
      check("ed_count", sym_count, 4);
      repeat (10) tick();
      check("ed_quiet", nbeats - base_b, 64);
      check("ed_busy", busy, 0);
      exp_inv = 1'b0;

      // async reset at bin 30
      base_b = nbeats;
      en = 1'b1;
      wait_beats(base_b + 30, 200);
      #1;
      rst = 1'b1;
      #1;
      check("mr_ctl", {st.fft_ii_0_sink_valid, st.fft_ii_0_sink_startofpacket,
                       st.fft_ii_0_sink_endofpacket, st.fft_ii_0_sink_error,
                       st.sym_ready, busy}, 7'd0);
      check("mr_data", st.fft_ii_0_sink_data, 0);
      check("mr_count", sym_count, 0);
      exp_k = 0;
      q.delete();
      tick();
      tick();
      rst = 1'b0;
      base_b = nbeats;
      wait_beats(base_b + 1, 50);
      check("mr_sop", last_sop, 1);
      en = 1'b0;
      wait_idle(200);
      check("mr_beats", nbeats - base_b, 64);
      check("mr_count1", sym_count, 1);

      // sym_count wrap from 0xFFFF
      @(negedge clk);
      force dut.count_q = 16'hFFFF;
      tick();
      release dut.count_q;
      @(negedge clk);
      check("wrap_pre", sym_count, 16'hFFFF);
      tick();
      en = 1'b1;
      tick();
      en = 1'b0;
      wait_idle(200);
      check("wrap", sym_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
